// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // The merge helper works on a fixed maximum width; callers zero-extend
    // their word and mask into it and truncate the result back.
    localparam int MAX_W  = 256;
    localparam int MAX_NB = MAX_W / 8;

    function automatic int num_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Bytes with mask=1 come from new_w, all others keep old_w.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_NB-1:0] mask
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_out_stage.sv
// One-stage read pipeline: data is captured only with a valid beat so the
// output holds its last read result between reads.
module ram_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Register the read beat; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/param_ram.sv
// Parametrised single-port RAM with byte enables, write-first reads, an
// optional output register and a post-reset zeroing sweep.
module param_ram
    import ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   dIn,
    input  logic [ADDR_W-1:0]   adr,
    input  logic                writeEn,
    input  logic [DATA_W/8-1:0] byteEn,
    input  logic                readEn,
    output logic [DATA_W-1:0]   dOut,
    output logic                dValid,
    output logic                busy
);

    localparam int              NB      = num_bytes(DATA_W);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    ram_state_e          state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;

    // No reset on the array so it maps onto RAM primitives.
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                in_range;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   merged_word;
    logic [DATA_W-1:0]   rd_data_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    // Request qualification and write-first data selection.
    always_comb begin
        in_range    = ({1'b0, adr} < DEPTH_L);
        wr_acc      = !reset && (state_q == READY) && writeEn && in_range;
        rd_acc      = !reset && (state_q == READY) && readEn && in_range;
        rd_word     = mem[adr];
        merged_word = DATA_W'(byte_merge(MAX_W'(rd_word), MAX_W'(dIn),
                                         MAX_NB'(byteEn[NB-1:0])));
        rd_data_d   = writeEn ? merged_word : rd_word;
    end

    // Sequencer: sweep every word to zero after reset, then serve requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == LAST) begin
                        state_q <= READY;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                READY:   state_q <= READY;
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Storage write port: sweep zeroes take priority over user writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_acc) begin
                mem[adr] <= merged_word;
            end
        end
    end

    // First read stage; data only moves with an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            ram_out_stage #(
                .DATA_W (DATA_W)
            ) u_out_stage (
                .clk     (clk),
                .reset   (reset),
                .data_i  (rd_data_q),
                .valid_i (rd_valid_q),
                .data_o  (dOut),
                .valid_o (dValid)
            );
        end else begin : g_out_bypass
            assign dOut   = rd_data_q;
            assign dValid = rd_valid_q;
        end
    endgenerate

    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// Randomised bench for param_ram: two instances (16-bit x16 with no output
// register, 8-bit x6 in a 3-bit space with output register) run against a
// behavioural memory model with a fixed read-latency delay line.
module tb_param_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        s_rst [2];
    logic [15:0] s_din [2];
    logic [3:0]  s_adr [2];
    logic        s_we  [2];
    logic        s_re  [2];
    logic [1:0]  s_be  [2];

    logic        a_busy, a_dv;
    logic [15:0] a_do;
    logic        b_busy, b_dv;
    logic [7:0]  b_do;

    param_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .OUT_REG(0)) u_a (
        .clk     (clk),
        .reset   (s_rst[0]),
        .dIn     (s_din[0]),
        .adr     (s_adr[0]),
        .writeEn (s_we[0]),
        .byteEn  (s_be[0]),
        .readEn  (s_re[0]),
        .dOut    (a_do),
        .dValid  (a_dv),
        .busy    (a_busy)
    );

    param_ram #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .OUT_REG(1)) u_b (
        .clk     (clk),
        .reset   (s_rst[1]),
        .dIn     (s_din[1][7:0]),
        .adr     (s_adr[1][2:0]),
        .writeEn (s_we[1]),
        .byteEn  (s_be[1][0]),
        .readEn  (s_re[1]),
        .dOut    (b_do),
        .dValid  (b_dv),
        .busy    (b_busy)
    );

    // Reference model state
    int          DW  [2] = '{16, 8};
    int          DEP [2] = '{16, 6};
    int          LAT [2] = '{1, 2};
    logic [15:0] mem_m [2][16];
    int          clr_left [2];
    logic        v1 [2];
    logic [15:0] d1 [2];
    logic        ov [2];
    logic [15:0] od [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        logic [15:0] cur, mrg;
        bit          inr, idle, acc_wr, acc_rd;
        if (s_rst[k]) begin
            clr_left[k] = DEP[k];
            v1[k] = 1'b0; d1[k] = '0; ov[k] = 1'b0; od[k] = '0;
            return;
        end
        idle = (clr_left[k] == 0);
        inr  = (int'(s_adr[k]) < DEP[k]);
        cur  = inr ? mem_m[k][s_adr[k]] : 16'h0;
        mrg  = cur;
        for (int i = 0; i < DW[k] / 8; i++)
            if (s_be[k][i]) mrg[8*i +: 8] = s_din[k][8*i +: 8];
        acc_wr = idle && s_we[k] && inr;
        acc_rd = idle && s_re[k] && inr;
        if (acc_wr) mem_m[k][s_adr[k]] = mrg;
        if (!idle) begin
            clr_left[k]--;
            if (clr_left[k] == 0)
                for (int j = 0; j < 16; j++) mem_m[k][j] = '0;
        end
        if (LAT[k] == 1) begin
            ov[k] = acc_rd;
            if (acc_rd) od[k] = s_we[k] ? mrg : cur;
        end else begin
            ov[k] = v1[k];
            if (v1[k]) od[k] = d1[k];
            v1[k] = acc_rd;
            if (acc_rd) d1[k] = s_we[k] ? mrg : cur;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("a_busy",   32'(a_busy), 32'(clr_left[0] != 0));
        chk("a_dvalid", 32'(a_dv),   32'(ov[0]));
        chk("a_dout",   32'(a_do),   32'(od[0]));
        chk("b_busy",   32'(b_busy), 32'(clr_left[1] != 0));
        chk("b_dvalid", 32'(b_dv),   32'(ov[1]));
        chk("b_dout",   32'(b_do),   32'(od[1][7:0]));
    endtask

    task automatic set_in(input int k, input bit rst, input bit we, input bit re,
                          input int adr, input logic [15:0] din, input logic [1:0] be);
        s_rst[k] = rst;
        s_we[k]  = we;
        s_re[k]  = re;
        if (k == 0) begin
            s_adr[k] = 4'(adr);
            s_din[k] = din;
            s_be[k]  = be;
        end else begin
            s_adr[k] = {1'b0, 3'(adr)};
            s_din[k] = {8'h00, din[7:0]};
            s_be[k]  = {1'b0, be[0]};
        end
    endtask

    task automatic idle_all();
        set_in(0, 0, 0, 0, 0, 16'h0, 2'b00);
        set_in(1, 0, 0, 0, 0, 16'h0, 2'b00);
    endtask

    initial begin
        int cnt_a, cnt_b, cnt;
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = DEP[k];
            v1[k] = 1'b0; d1[k] = '0; ov[k] = 1'b0; od[k] = '0;
            for (int j = 0; j < 16; j++) mem_m[k][j] = '0;
        end

        // Two-cycle reset, then measure the sweep length on both instances
        set_in(0, 1, 0, 0, 0, 16'h0, 2'b00);
        set_in(1, 1, 0, 0, 0, 16'h0, 2'b00);
        cycle();
        cycle();
        idle_all();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_busy) cnt_a++;
            if (b_busy) cnt_b++;
            cycle();
        end
        chk("a_sweep_len", 32'(cnt_a), 32'd16);
        chk("b_sweep_len", 32'(cnt_b), 32'd6);

        // Every word reads back as zero after the sweep
        for (int a = 0; a < 16; a++) begin
            set_in(0, 0, 0, 1, a, 16'h0, 2'b00);
            set_in(1, 0, 0, (a < 6), a, 16'h0, 2'b00);
            cycle();
        end
        idle_all(); cycle(); cycle();

        // Byte mask on the 16-bit instance
        set_in(0, 0, 1, 0, 3, 16'hAABB, 2'b11); cycle();
        set_in(0, 0, 1, 0, 3, 16'h1122, 2'b01); cycle();
        set_in(0, 0, 0, 1, 3, 16'h0, 2'b00);    cycle();
        chk("bytemask_dout", 32'(a_do), 32'h0000AA22);
        chk("bytemask_dv",   32'(a_dv), 32'd1);

        // Write-first on a zero word
        set_in(0, 0, 1, 1, 5, 16'h005A, 2'b11); cycle();
        chk("wfirst_dout", 32'(a_do), 32'h0000005A);
        chk("wfirst_dv",   32'(a_dv), 32'd1);
        idle_all(); cycle();
        set_in(0, 0, 0, 1, 5, 16'h0, 2'b00); cycle();
        chk("wfirst_later", 32'(a_do), 32'h0000005A);
        idle_all(); cycle();

        // Two-cycle latency with the output register
        set_in(1, 0, 1, 0, 0, 16'h003C, 2'b01); cycle();
        set_in(1, 0, 0, 1, 0, 16'h0, 2'b00);    cycle();
        chk("oreg_n_dv", 32'(b_dv), 32'd0);
        idle_all(); cycle();
        chk("oreg_n1_dv",   32'(b_dv), 32'd1);
        chk("oreg_n1_dout", 32'(b_do), 32'h3C);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(1, 0, 0, 1, i, 16'h0, 2'b00);
            else       set_in(1, 0, 0, 0, 0, 16'h0, 2'b00);
            cycle();
            if (b_dv) cnt++;
        end
        chk("oreg_stream_cnt", 32'(cnt), 32'd4);

        // Out-of-range write and read are dropped
        set_in(1, 0, 1, 0, 7, 16'h00FF, 2'b01); cycle();
        set_in(1, 0, 0, 1, 7, 16'h0, 2'b00);    cycle();
        idle_all(); cycle();
        chk("oor_read_dv", 32'(b_dv), 32'd0);
        for (int a = 0; a < 6; a++) begin
            set_in(1, 0, 0, 1, a, 16'h0, 2'b00); cycle();
        end
        idle_all(); cycle(); cycle();

        // Requests during the sweep are dropped
        set_in(1, 1, 0, 0, 0, 16'h0, 2'b00); cycle();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 1, 1, 1, 16'h0077, 2'b01); cycle();
        end
        set_in(1, 0, 0, 1, 1, 16'h0, 2'b00); cycle();
        idle_all(); cycle(); cycle();

        // Reset in the middle of a streamed read
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 1, i, 16'h0, 2'b00); cycle();
        end
        set_in(1, 1, 0, 1, 3, 16'h0, 2'b00); cycle();
        chk("rst_mid_dv", 32'(b_dv), 32'd0);
        idle_all();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_busy) cnt++;
            cycle();
        end
        chk("rst_mid_sweep_len", 32'(cnt), 32'd6);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            set_in(0, ($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
            set_in(1, ($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 7)), 16'($urandom), 2'($urandom));
            cycle();
        end
        idle_all(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
